seq_math_unit: RTL and testbench

- Multi-cycle, parametrised successor to the combinational square/cube/factorial function unit.
- Computes square, cube, factorial and integer power using one shared iterative multiplier, one multiply per clock.
- Start/busy/done handshake; registered outputs with overflow and illegal-opcode flags.
- Sits behind a control sequencer that issues one operation at a time.

---
 rtl/seq_math_unit.sv | 144 ++++++++++++++
 tb/tb_seq_math_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_math_unit.sv
// seq_math_unit: multi-cycle square / cube / factorial / integer power unit.
// A single shared multiplier performs one multiply per clock. The iteration
// counter doubles as the factorial down-counter.
// Optional build macro: SEQ_MATH_SATURATE_EN. When it is defined, an
// overflowed result is reported as all-ones instead of the truncated value.
module seq_math_unit #(
   parameter int N_W   = 4,
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic [N_W-1:0]   n,
   input  logic [N_W-1:0]   m,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] out,
   output logic             overflow,
   output logic             err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_is_fact;
   logic [N_W-1:0]     r_n;
   logic [N_W-1:0]     r_cnt;
   logic [OUT_W-1:0]   r_acc;
   logic               r_acc_ovf;
   logic               r_busy;
   logic               r_done;
   logic [OUT_W-1:0]   r_out;
   logic               r_overflow;
   logic               r_err;

   logic [N_W-1:0]     w_load_k;
   logic               w_illegal;
   logic [N_W-1:0]     w_factor;
   logic [2*OUT_W-1:0] w_prod;
   logic [OUT_W-1:0]   w_prod_lo;
   logic               w_step_ovf;
   logic [OUT_W-1:0]   w_final_out;

   // Iteration count and legality of the opcode presented at start
   always_comb begin
      w_load_k  = '0;
      w_illegal = 1'b0;
      case (opcode)
         3'd0:    w_load_k = N_W'(2);
         3'd1:    w_load_k = N_W'(3);
         3'd2:    w_load_k = n;
         3'd3:    w_load_k = m;
         default: w_illegal = 1'b1;
      endcase
   end

   // Factorial multiplies by the counter, every other op by the captured base
   assign w_factor  = r_is_fact ? r_cnt : r_n;
   assign w_prod    = {{OUT_W{1'b0}}, r_acc} * {{(2*OUT_W-N_W){1'b0}}, w_factor};
   assign w_prod_lo = w_prod[OUT_W-1:0];
   // Overflow is sticky across the iterations of one operation
   assign w_step_ovf = (|w_prod[2*OUT_W-1:OUT_W]) | r_acc_ovf;

`ifdef SEQ_MATH_SATURATE_EN
   assign w_final_out = w_step_ovf ? {OUT_W{1'b1}} : w_prod_lo;
`else
   assign w_final_out = w_prod_lo;
`endif

   // Control FSM, datapath and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_is_fact  <= 1'b0;
         r_n        <= '0;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_acc_ovf  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_out      <= '0;
         r_overflow <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_is_fact <= (opcode == 3'd2);
                  r_n       <= n;
                  r_acc     <= OUT_W'(1);
                  r_acc_ovf <= 1'b0;
                  r_busy    <= 1'b1;
                  if (w_load_k != '0) begin
                     r_cnt   <= w_load_k;
                     r_state <= S_CALC;
                  end else begin
                     // Zero iterations: result is the empty product, or 0 if illegal
                     r_cnt      <= '0;
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_out      <= w_illegal ? '0 : OUT_W'(1);
                     r_overflow <= 1'b0;
                     r_err      <= w_illegal;
                  end
               end
            end
            S_CALC: begin
               r_acc     <= w_prod_lo;
               r_acc_ovf <= w_step_ovf;
               r_cnt     <= r_cnt - N_W'(1);
               if (r_cnt == N_W'(1)) begin
                  r_state    <= S_DONE;
                  r_done     <= 1'b1;
                  r_out      <= w_final_out;
                  r_overflow <= w_step_ovf;
                  r_err      <= 1'b0;
               end
            end
            S_DONE: begin
               // Any start seen here is dropped; the requester must retry from IDLE
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign out      = r_out;
   assign overflow = r_overflow;
   assign err      = r_err;

endmodule

// File: tb/tb_seq_math_unit.sv
// Directed bench for seq_math_unit: vector table plus hand-written
// handshake and mid-operation reset sequences.
module tb_seq_math_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  opcode;
   logic [3:0]  n;
   logic [3:0]  m;
   logic        busy;
   logic        done;
   logic [15:0] out;
   logic        overflow;
   logic        err;

   int total;
   int bad;

   seq_math_unit #(.N_W(4), .OUT_W(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .opcode   (opcode),
      .n        (n),
      .m        (m),
      .busy     (busy),
      .done     (done),
      .out      (out),
      .overflow (overflow),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  nn;
      logic [3:0]  mm;
      logic [15:0] exp_out;
      logic        exp_ovf;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

`ifdef SEQ_MATH_SATURATE_EN
   localparam logic [15:0] FACT9 = 16'd65535;
`else
   localparam logic [15:0] FACT9 = 16'd35200;
`endif

   task automatic check(input string nm, input longint got, input longint want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   // One operation: start at a negedge, accepted at the next posedge (E0);
   // then sample #1 after each edge, cycle c=1 being the one after E0.
   task automatic do_op(input logic [2:0] op, input logic [3:0] nn, input logic [3:0] mm,
                        output int lat, output logic [15:0] o, output logic ov,
                        output logic er, output int pulses);
      lat    = 0;
      pulses = 0;
      o      = '0;
      ov     = 1'b0;
      er     = 1'b0;
      @(negedge clk);
      start  = 1'b1;
      opcode = op;
      n      = nn;
      m      = mm;
      @(posedge clk);
      #1;
      start  = 1'b0;
      n      = ~nn;
      m      = ~mm;
      opcode = 3'd1;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin
            pulses++;
            if (lat == 0) begin
               lat = c;
               o   = out;
               ov  = overflow;
               er  = err;
            end
         end
         if (!busy && lat != 0) break;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int          lat;
      int          pulses;
      logic [15:0] o;
      logic        ov;
      logic        er;

      total  = 0;
      bad    = 0;
      reset  = 1'b0;
      start  = 1'b0;
      opcode = 3'd0;
      n      = 4'd0;
      m      = 4'd0;

      vecs[0]  = '{3'd0, 4'd13, 4'd0, 16'd169,   1'b0, 1'b0, 3};
      vecs[1]  = '{3'd1, 4'd15, 4'd0, 16'd3375,  1'b0, 1'b0, 4};
      vecs[2]  = '{3'd2, 4'd8,  4'd0, 16'd40320, 1'b0, 1'b0, 9};
      vecs[3]  = '{3'd2, 4'd0,  4'd0, 16'd1,     1'b0, 1'b0, 1};
      vecs[4]  = '{3'd2, 4'd9,  4'd0, FACT9,     1'b1, 1'b0, 10};
      vecs[5]  = '{3'd3, 4'd2,  4'd15, 16'd32768, 1'b0, 1'b0, 16};
      vecs[6]  = '{3'd3, 4'd2,  4'd0, 16'd1,     1'b0, 1'b0, 1};
      vecs[7]  = '{3'd3, 4'd0,  4'd3, 16'd0,     1'b0, 1'b0, 4};
      vecs[8]  = '{3'd2, 4'd1,  4'd0, 16'd1,     1'b0, 1'b0, 2};
      vecs[9]  = '{3'd7, 4'd4,  4'd4, 16'd0,     1'b0, 1'b1, 1};
      vecs[10] = '{3'd3, 4'd15, 4'd4, 16'd50625, 1'b0, 1'b0, 5};
      vecs[11] = '{3'd0, 4'd15, 4'd0, 16'd225,   1'b0, 1'b0, 3};
      vecs[12] = '{3'd0, 4'd0,  4'd0, 16'd0,     1'b0, 1'b0, 3};
      vecs[13] = '{3'd1, 4'd1,  4'd0, 16'd1,     1'b0, 1'b0, 4};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", overflow, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_busy", busy, 0);
      check("post_rst_out", out, 0);

      // Vector table
      for (int i = 0; i < NV; i++) begin
         do_op(vecs[i].op, vecs[i].nn, vecs[i].mm, lat, o, ov, er, pulses);
         $display("vec %0d op=%0d n=%0d m=%0d -> out=%0d ovf=%0d err=%0d lat=%0d pulses=%0d",
                  i, vecs[i].op, vecs[i].nn, vecs[i].mm, o, ov, er, lat, pulses);
         check($sformatf("v%0d_out", i), o, vecs[i].exp_out);
         check($sformatf("v%0d_ovf", i), ov, vecs[i].exp_ovf);
         check($sformatf("v%0d_err", i), er, vecs[i].exp_err);
         check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         check($sformatf("v%0d_pulses", i), pulses, 1);
      end

      // Handshake: cube of 3 with stray starts in CALC and in the DONE cycle
      begin
         int hs_pulses;
         int hs_lat;
         logic [15:0] hs_out;
         hs_pulses = 0;
         hs_lat    = 0;
         hs_out    = '0;
         @(negedge clk);
         start  = 1'b1;
         opcode = 3'd1;
         n      = 4'd3;
         m      = 4'd0;
         @(posedge clk);
         #1;
         start = 1'b0;
         for (int c = 1; c <= 12; c++) begin
            if (done) begin
               hs_pulses++;
               if (hs_lat == 0) begin
                  hs_lat = c;
                  hs_out = out;
               end
            end
            if (c == 2) begin
               check("hs_busy_calc", busy, 1);
               check("hs_out_held", out, 1);
               start  = 1'b1;
               opcode = 3'd0;
               n      = 4'd5;
            end
            if (c == 3) start = 1'b0;
            if (c == 4) begin
               start  = 1'b1;
               opcode = 3'd0;
               n      = 4'd7;
            end
            if (c == 5) start = 1'b0;
            @(posedge clk);
            #1;
         end
         $display("handshake cube(3) -> out=%0d lat=%0d pulses=%0d busy=%0d",
                  hs_out, hs_lat, hs_pulses, busy);
         check("hs_pulses", hs_pulses, 1);
         check("hs_lat", hs_lat, 4);
         check("hs_out", hs_out, 27);
         check("hs_idle_after", busy, 0);
      end

      // Illegal opcode right after the handshake
      do_op(3'd5, 4'd3, 4'd3, lat, o, ov, er, pulses);
      $display("illegal op=5 -> out=%0d ovf=%0d err=%0d lat=%0d", o, ov, er, lat);
      check("ill_out", o, 0);
      check("ill_err", er, 1);
      check("ill_ovf", ov, 0);
      check("ill_lat", lat, 1);

      // Leave overflow and out nonzero, then reset in the middle of 3^10
      do_op(3'd2, 4'd9, 4'd0, lat, o, ov, er, pulses);
      check("pre_rst_ovf", overflow, 1);
      begin
         int rst_done_seen;
         rst_done_seen = 0;
         @(negedge clk);
         start  = 1'b1;
         opcode = 3'd3;
         n      = 4'd3;
         m      = 4'd10;
         @(posedge clk);
         #1;
         start = 1'b0;
         repeat (3) @(posedge clk);
         #2;
         reset = 1'b0;
         #1;
         $display("mid reset -> out=%0d ovf=%0d err=%0d busy=%0d done=%0d",
                  out, overflow, err, busy, done);
         check("mrst_out", out, 0);
         check("mrst_ovf", overflow, 0);
         check("mrst_busy", busy, 0);
         check("mrst_done", done, 0);
         check("mrst_err", err, 0);
         for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (done) rst_done_seen++;
         end
         @(negedge clk);
         reset = 1'b1;
         for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done) rst_done_seen++;
         end
         check("mrst_no_done", rst_done_seen, 0);
         check("mrst_idle", busy, 0);
      end
      do_op(3'd3, 4'd3, 4'd10, lat, o, ov, er, pulses);
      $display("after reset 3^10 -> out=%0d ovf=%0d lat=%0d pulses=%0d", o, ov, lat, pulses);
      check("rec_out", o, 59049);
      check("rec_ovf", ov, 0);
      check("rec_lat", lat, 11);
      check("rec_pulses", pulses, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
